// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared defaults, FSM state type and helpers for the mips
//               bus memory harness.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int MIPS_WIDTH    = 8;
    localparam int MIPS_ADDR_W   = 8;
    localparam int MIPS_DONE_ADR = 'h4C;
    localparam int MIPS_DONE_VAL = 7;
    localparam int CNT_W         = 16;
    localparam int LAT_W         = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Saturating increment for the traffic counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_array
// Description : DEPTH x WIDTH storage with one synchronous write port and
//               one asynchronous read port. Contents are never reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_array #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wadr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDX_W-1:0] radr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single write port; the caller has already muxed preload vs core write.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[wadr] <= wdata;
        end
    end

    assign rdata = r_mem[radr];

endmodule
`default_nettype wire

// File: rtl/mips_bus_mem.sv
`default_nettype none
// ============================================================================
// Module      : mips_bus_mem
// Description : Bus memory for the multicycle mips core with configurable
//               read latency, preload port, traffic counters and sticky
//               program-completion detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_bus_mem
    import mips_pkg::*;
#(
    parameter int WIDTH    = MIPS_WIDTH,
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int DEPTH    = 256,
    parameter int RD_LAT   = 1,
    parameter int DONE_ADR = MIPS_DONE_ADR,
    parameter int DONE_VAL = MIPS_DONE_VAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] adr,
    input  logic [WIDTH-1:0]  writedata,
    output logic [WIDTH-1:0]  memdata,
    output logic              memvalid,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_adr,
    input  logic [WIDTH-1:0]  ld_data,
    output logic              done,
    output logic              pass,
    output logic              err,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t             r_state;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [WIDTH-1:0]   r_rd_data;

    logic               w_adr_ok;
    logic               w_ld_ok;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_err_evt;
    logic               w_we;
    logic [IDX_W-1:0]   w_wadr;
    logic [WIDTH-1:0]   w_wdata;
    logic [WIDTH-1:0]   w_arr_rdata;
    logic [WIDTH-1:0]   w_rd_data;

    assign w_adr_ok = (32'(adr) < DEPTH);
    assign w_ld_ok  = (32'(ld_adr) < DEPTH);

    // Preload owns the cycle; a simultaneous read+write keeps only the write.
    assign w_wr_acc = memwrite && !ld_en && w_adr_ok;
    assign w_rd_acc = memread && !memwrite && !ld_en && (r_state == IDLE);

    assign w_err_evt = !ld_en &&
                       ((memread && (memwrite || (r_state == WAIT))) ||
                        ((memread || memwrite) && !w_adr_ok));

    assign w_we    = ld_en ? w_ld_ok : w_wr_acc;
    assign w_wadr  = ld_en ? ld_adr[IDX_W-1:0] : adr[IDX_W-1:0];
    assign w_wdata = ld_en ? ld_data : writedata;

    // Out-of-range reads return zero rather than aliasing into the array.
    assign w_rd_data = w_adr_ok ? w_arr_rdata : '0;

    mips_mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (w_we),
        .wadr  (w_wadr),
        .wdata (w_wdata),
        .radr  (adr[IDX_W-1:0]),
        .rdata (w_arr_rdata)
    );

    // Read FSM: capture at accept, deliver memdata/memvalid after RD_LAT-1 more edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_lat_cnt <= '0;
            r_rd_data <= '0;
            memdata   <= '0;
            memvalid  <= 1'b0;
        end else begin
            memvalid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rd_acc) begin
                        if (RD_LAT <= 1) begin
                            memdata  <= w_rd_data;
                            memvalid <= 1'b1;
                        end else begin
                            r_rd_data <= w_rd_data;
                            r_lat_cnt <= LAT_W'(RD_LAT - 1);
                            r_state   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (r_lat_cnt == LAT_W'(1)) begin
                        memdata  <= r_rd_data;
                        memvalid <= 1'b1;
                        r_state  <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Sticky flags and saturating traffic counters; done/pass freeze on first completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            done     <= 1'b0;
            pass     <= 1'b0;
            err      <= 1'b0;
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (w_err_evt) begin
                err <= 1'b1;
            end
            if (w_rd_acc) begin
                rd_count <= sat_inc(rd_count);
            end
            if (w_wr_acc) begin
                wr_count <= sat_inc(wr_count);
            end
            if (w_wr_acc && !done && (adr == ADDR_W'(DONE_ADR))) begin
                done <= 1'b1;
                pass <= (writedata == WIDTH'(DONE_VAL));
            end
        end
    end

endmodule
`default_nettype wire
